// File: rtl/cfg_types_pkg.sv
// Shared types and constants for the accelerator control bank.
//   ch_state_t    : per-channel run state (IDLE, RUN)
//   GLB_*         : word offsets inside the global block that follows the
//                   channel windows
//   ST0_* / CTRL0_*: bit positions in status word 0 and control word 0
//   win_log2()    : log2 of the per-channel address window size
package cfg_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  localparam int GLB_IRQ_EN   = 0;
  localparam int GLB_IRQ_PEND = 1;

  localparam int ST0_BUSY   = 0;
  localparam int ST0_PEND   = 1;
  localparam int ST0_WR_ERR = 2;

  localparam int CTRL0_START = 0;
  localparam int CTRL0_ABORT = 1;

  // Each channel window is padded up to a power of two so channel index and
  // word offset are plain bit fields of the word address.
  function automatic int win_log2(input int ctrl_words, input int stat_words);
    return $clog2(ctrl_words + stat_words);
  endfunction

endpackage

// File: rtl/accel_ch_ctrl.sv
// One accelerator channel: IDLE/RUN state machine, control word storage and
// the sticky write-error flag.
//   ctrl_wr / st0_wr : decoded bus write to one of this channel's control
//                      words / to its status word 0
//   wr_off           : word offset inside the channel window
//   be_i, wdata_i    : byte enables and write data of the bus write
//   done_i           : completion pulse from the accelerator
//   ctrl_o           : control words, word 0 in the low slice
//   start_o, abort_o : registered one-cycle pulses
//   busy_o           : channel is in RUN
//   done_evt_o       : accepted completion (sets the pending bit upstream)
//   wr_err_o         : sticky "control write while running" flag
module accel_ch_ctrl
  import cfg_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WORDS = 2,
  parameter int OFF_W      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ctrl_wr,
  input  logic                             st0_wr,
  input  logic [OFF_W-1:0]                 wr_off,
  input  logic [DATA_WIDTH/8-1:0]          be_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic                             done_i,
  output logic [CTRL_WORDS*DATA_WIDTH-1:0] ctrl_o,
  output logic                             start_o,
  output logic                             abort_o,
  output logic                             busy_o,
  output logic                             done_evt_o,
  output logic                             wr_err_o
);

  localparam int NB = DATA_WIDTH / 8;

  ch_state_t             state_reg;
  logic                  start_reg;
  logic                  abort_reg;
  logic                  wr_err_reg;
  logic                  start_req;
  logic                  abort_req;
  logic                  ctrl_accept;
  logic [DATA_WIDTH-1:0] lane_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_mask[gi*8 +: 8] = {8{be_i[gi]}};
    end
  endgenerate

  assign start_req   = ctrl_wr && (wr_off == '0) && be_i[0] && wdata_i[CTRL0_START];
  assign abort_req   = ctrl_wr && (wr_off == '0) && be_i[0] && wdata_i[CTRL0_ABORT];
  // Control words are only writable while the channel is idle.
  assign ctrl_accept = ctrl_wr && (state_reg == IDLE);

  generate
    for (gi = 0; gi < CTRL_WORDS; gi++) begin : g_word
      // Start/abort bits of word 0 are commands, never stored.
      localparam logic [DATA_WIDTH-1:0] KEEP = (gi == 0) ? ~DATA_WIDTH'(3) : '1;
      logic [DATA_WIDTH-1:0] word_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (ctrl_accept && (wr_off == OFF_W'(gi))) begin
          word_reg <= ((word_reg & ~lane_mask) | (wdata_i & lane_mask)) & KEEP;
        end
      end
      assign ctrl_o[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      start_reg  <= 1'b0;
      abort_reg  <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      abort_reg <= 1'b0;
      if (st0_wr && be_i[0] && wdata_i[ST0_WR_ERR]) begin
        wr_err_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (start_req) begin
            start_reg <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // An abort command is a legal write in RUN; anything else is dropped.
          if (ctrl_wr && !abort_req) begin
            wr_err_reg <= 1'b1;
          end
          // Completion takes priority over a simultaneous abort.
          if (done_i) begin
            state_reg <= IDLE;
          end else if (abort_req) begin
            abort_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign start_o    = start_reg;
  assign abort_o    = abort_reg;
  assign busy_o     = (state_reg == RUN);
  assign done_evt_o = (state_reg == RUN) && done_i;
  assign wr_err_o   = wr_err_reg;

endmodule

// File: rtl/accel_ctrl_bank.sv
// Register bank controlling N_CH accelerator channels over a simple
// always-ready word bus.
//   req_i/we_i/addr_i/be_i/wdata_i : bus request, one access per cycle
//   rdata_o : read data, one cycle after a read, held otherwise
//   ctrl_o  : all control words, channel-major
//   stat_i  : external status words 1..STAT_WORDS-1, channel-major
//   start_o/abort_o/done_i : per-channel command pulses and completion
//   irq_o   : registered OR of enabled pending completions
// Map: channel c at c*W (ctrl words, then status words), global block at
// N_CH*W holding IRQ_EN and IRQ_PEND (W1C).
module accel_ctrl_bank
  import cfg_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 2,
  parameter int CTRL_WORDS = 2,
  parameter int STAT_WORDS = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_i,
  input  logic                                  we_i,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  input  logic [DATA_WIDTH/8-1:0]               be_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_i,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic [N_CH*CTRL_WORDS*DATA_WIDTH-1:0] ctrl_o,
  input  logic [N_CH*(STAT_WORDS-1)*DATA_WIDTH-1:0] stat_i,
  output logic [N_CH-1:0]                       start_o,
  output logic [N_CH-1:0]                       abort_o,
  input  logic [N_CH-1:0]                       done_i,
  output logic                                  irq_o
);

  localparam int LOG_W    = win_log2(CTRL_WORDS, STAT_WORDS);
  localparam int W        = 1 << LOG_W;
  localparam int GLB_BASE = N_CH * W;
  localparam int CW       = CTRL_WORDS * DATA_WIDTH;

  logic [31:0]           addr_w;
  logic [31:0]           ch_idx;
  logic [31:0]           off_idx;
  logic                  in_ch;
  logic                  wr_cyc;
  logic                  rd_cyc;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done_evt;
  logic [N_CH-1:0]       wr_err;
  logic [N_CH-1:0]       en_reg;
  logic [N_CH-1:0]       en_next;
  logic [N_CH-1:0]       pend_reg;
  logic [N_CH-1:0]       pend_next;
  logic [N_CH-1:0]       pend_clr;
  logic                  en_wr;
  logic                  irq_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign addr_w  = 32'(addr_i);
  assign ch_idx  = addr_w >> LOG_W;
  assign off_idx = addr_w & 32'(W - 1);
  assign in_ch   = addr_w < 32'(GLB_BASE);
  assign wr_cyc  = req_i && we_i;
  assign rd_cyc  = req_i && !we_i;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic hit;
      assign hit = wr_cyc && in_ch && (ch_idx == 32'(gi));
      accel_ch_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WORDS (CTRL_WORDS),
        .OFF_W      (LOG_W)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .ctrl_wr    (hit && (off_idx < 32'(CTRL_WORDS))),
        .st0_wr     (hit && (off_idx == 32'(CTRL_WORDS))),
        .wr_off     (addr_i[LOG_W-1:0]),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .done_i     (done_i[gi]),
        .ctrl_o     (ctrl_o[gi*CW +: CW]),
        .start_o    (start_o[gi]),
        .abort_o    (abort_o[gi]),
        .busy_o     (busy[gi]),
        .done_evt_o (done_evt[gi]),
        .wr_err_o   (wr_err[gi])
      );
    end
  endgenerate

  assign en_wr     = wr_cyc && (addr_w == 32'(GLB_BASE + GLB_IRQ_EN)) && be_i[0];
  assign pend_clr  = (wr_cyc && (addr_w == 32'(GLB_BASE + GLB_IRQ_PEND)) && be_i[0])
                   ? wdata_i[N_CH-1:0] : '0;
  assign en_next   = en_wr ? wdata_i[N_CH-1:0] : en_reg;
  // A completion in the same cycle as a W1C clear keeps the bit set.
  assign pend_next = (pend_reg & ~pend_clr) | done_evt;

  always_comb begin
    rd_mux = '0;
    if (in_ch) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_idx == 32'(c)) begin
          for (int k = 0; k < CTRL_WORDS; k++) begin
            if (off_idx == 32'(k)) rd_mux = ctrl_o[(c*CTRL_WORDS + k)*DATA_WIDTH +: DATA_WIDTH];
          end
          if (off_idx == 32'(CTRL_WORDS)) begin
            rd_mux = DATA_WIDTH'({wr_err[c], pend_reg[c], busy[c]});
          end
          for (int j = 1; j < STAT_WORDS; j++) begin
            if (off_idx == 32'(CTRL_WORDS + j)) begin
              rd_mux = stat_i[(c*(STAT_WORDS-1) + j - 1)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end else if (addr_w == 32'(GLB_BASE + GLB_IRQ_EN)) begin
      rd_mux = DATA_WIDTH'(en_reg);
    end else if (addr_w == 32'(GLB_BASE + GLB_IRQ_PEND)) begin
      rd_mux = DATA_WIDTH'(pend_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg    <= '0;
      pend_reg  <= '0;
      irq_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      en_reg   <= en_next;
      pend_reg <= pend_next;
      irq_reg  <= |(pend_next & en_next);
      if (rd_cyc) rdata_reg <= rd_mux;
    end
  end

  assign rdata_o = rdata_reg;
  assign irq_o   = irq_reg;

endmodule

// File: tb/tb_accel_ctrl_bank.sv
module tb_accel_ctrl_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         we;
  logic [7:0]   addr;
  logic [3:0]   be;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic [127:0] ctrl;
  logic [63:0]  stat;
  logic [1:0]   start_p;
  logic [1:0]   abort_p;
  logic [1:0]   done;
  logic         irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_valid = 1'b0;

  accel_ctrl_bank dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .be_i    (be),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ctrl_o  (ctrl),
    .stat_i  (stat),
    .start_o (start_p),
    .abort_o (abort_p),
    .done_i  (done),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Read responses arrive one cycle after the request.
  always @(posedge clk) rd_valid <= req && !we && !rst;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic pulse_done(input logic [1:0] d);
    @(posedge clk); #1;
    done = d;
    @(posedge clk); #1;
    done = 2'b00;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; done = '0;
    stat = {32'hCAFE_0001, 32'h1234_5678};
    repeat (3) step();
    check("rst_start", 32'(start_p), 32'd0);
    check("rst_abort", 32'(abort_p), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    rd(8'd0, 32'h0, "rst_ch0_w0");
    rd(8'd8, 32'h0, "rst_irq_en");

    // Start channel 0.
    wr(8'd0, 32'h0000_0501, 4'hF);
    check("start0_pulse", 32'(start_p), 32'd1);
    step();
    check("start0_clear", 32'(start_p), 32'd0);
    rd(8'd0, 32'h0000_0500, "ch0_w0_after_start");
    rd(8'd2, 32'h1, "ch0_st0_busy");
    rd(8'd3, 32'h1234_5678, "ch0_stat1");

    // Completion with interrupt enabled, then W1C.
    wr(8'd8, 32'h1, 4'hF);
    pulse_done(2'b01);
    step();
    check("irq_set", 32'(irq), 32'd1);
    rd(8'd2, 32'h2, "ch0_st0_pend");
    rd(8'd9, 32'h1, "irq_pend_set");
    wr(8'd9, 32'h1, 4'hF);
    step();
    check("irq_cleared", 32'(irq), 32'd0);
    rd(8'd9, 32'h0, "irq_pend_clr");

    // Channel 1: write in RUN is dropped and flags WR_ERR.
    wr(8'd4, 32'h1, 4'hF);
    check("start1_pulse", 32'(start_p), 32'd2);
    wr(8'd5, 32'hDEAD_BEEF, 4'hF);
    rd(8'd5, 32'h0, "ch1_w1_dropped");
    rd(8'd6, 32'h5, "ch1_st0_err");
    wr(8'd6, 32'h4, 4'hF);
    rd(8'd6, 32'h1, "ch1_st0_err_clr");
    // done on an idle channel is ignored.
    pulse_done(2'b01);
    rd(8'd2, 32'h0, "ch0_idle_done_ignored");
    rd(8'd9, 32'h0, "pend_idle_done_ignored");
    // Abort channel 1.
    wr(8'd4, 32'h2, 4'hF);
    check("abort1_pulse", 32'(abort_p), 32'd2);
    rd(8'd6, 32'h0, "ch1_st0_after_abort");

    // Abort write coinciding with done: done wins.
    wr(8'd0, 32'h1, 4'hF);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 8'd0; wdata = 32'h2; be = 4'hF; done = 2'b01;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; done = 2'b00;
    check("abort_vs_done", 32'(abort_p), 32'd0);
    rd(8'd2, 32'h2, "ch0_st0_done_wins");
    wr(8'd9, 32'h1, 4'hF);
    // Separate abort.
    wr(8'd0, 32'h1, 4'hF);
    wr(8'd0, 32'h2, 4'hF);
    check("abort0_pulse", 32'(abort_p), 32'd1);
    step();
    check("abort0_clear", 32'(abort_p), 32'd0);
    rd(8'd2, 32'h0, "ch0_st0_after_abort");

    // Pending set and W1C clear in the same cycle: set wins.
    wr(8'd0, 32'h1, 4'hF);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 8'd9; wdata = 32'h1; be = 4'hF; done = 2'b01;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; done = 2'b00;
    rd(8'd9, 32'h1, "pend_set_wins");
    wr(8'd9, 32'h3, 4'hF);

    // Byte-lane writes and unmapped read.
    wr(8'd1, 32'h1122_3344, 4'hF);
    wr(8'd1, 32'hAABB_CCDD, 4'h2);
    rd(8'd1, 32'h1122_CC44, "ch0_w1_lane1");
    check("ctrl_o_ch0_w1", ctrl[63:32], 32'h1122_CC44);
    rd(8'd10, 32'h0, "unmapped_read");
    wr(8'd10, 32'hFFFF_FFFF, 4'hF);
    rd(8'd10, 32'h0, "unmapped_after_write");

    // Reset while running with an interrupt active.
    wr(8'd8, 32'h3, 4'hF);
    wr(8'd4, 32'h1, 4'hF);
    pulse_done(2'b10);
    wr(8'd0, 32'h1, 4'hF);
    step();
    check("irq_before_rst", 32'(irq), 32'd1);
    rd(8'd7, 32'hCAFE_0001, "ch1_stat1");
    rst = 1'b1;
    step();
    check("rstrun_irq", 32'(irq), 32'd0);
    check("rstrun_rdata", rdata, 32'd0);
    check("rstrun_abort", 32'(abort_p), 32'd0);
    check("rstrun_ctrl", ctrl[31:0], 32'd0);
    step();
    check("rstrun_abort2", 32'(abort_p), 32'd0);
    check("rstrun_start", 32'(start_p), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_abort", 32'(abort_p), 32'd0);
    rd(8'd0, 32'h0, "post_rst_w0");
    rd(8'd1, 32'h0, "post_rst_w1");
    rd(8'd2, 32'h0, "post_rst_st0");
    rd(8'd8, 32'h0, "post_rst_en");
    rd(8'd9, 32'h0, "post_rst_pend");

    repeat (3) step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accel_ctrl_bank.md
ACCEL_CTRL_BANK -- requirements
Module: accel_ctrl_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus and register word width.
REQ-002 SHALL have parameter N_CH, default 2, number of accelerator channels (1..8).
REQ-003 SHALL have parameter CTRL_WORDS, default 2, control words per channel (>=1).
REQ-004 SHALL have parameter STAT_WORDS, default 2, status words per channel (>=2). Word 0 is internal; words 1..STAT_WORDS-1 come from stat_i.
REQ-005 SHALL have parameter ADDR_WIDTH, default 8, word-address width.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req_i, input, 1, bus access request; always accepted.
REQ-009 SHALL have port we_i, input, 1, write enable.
REQ-010 SHALL have port addr_i, input, ADDR_WIDTH, word address.
REQ-011 SHALL have port be_i, input, DATA_WIDTH/8, byte enables.
REQ-012 SHALL have port wdata_i, input, DATA_WIDTH, write data.
REQ-013 SHALL have port rdata_o, output, DATA_WIDTH, read data, one cycle after the request.
REQ-014 SHALL have port ctrl_o, output, N_CH*CTRL_WORDS*DATA_WIDTH, flattened control words, channel-major.
REQ-015 SHALL have port stat_i, input, N_CH*(STAT_WORDS-1)*DATA_WIDTH, external status words.
REQ-016 SHALL have port start_o, output, N_CH, one-cycle start pulse per channel.
REQ-017 SHALL have port abort_o, output, N_CH, one-cycle abort pulse per channel.
REQ-018 SHALL have port done_i, input, N_CH, one-cycle completion pulse per channel.
REQ-019 SHALL have port irq_o, output, 1, registered interrupt.

Function
REQ-020 SHALL use address map: window W=2^clog2(CTRL_WORDS+STAT_WORDS); channel c occupies words c*W..c*W+W-1 (ctrl words first, then status words); global block at N_CH*W: +0 IRQ_EN, +1 IRQ_PEND.
REQ-021 SHALL return 0 for reads of unmapped addresses and silently drop writes to them and to status words.
REQ-022 SHALL apply writes per byte lane under be_i.
REQ-023 SHALL give reads fixed 1-cycle latency; rdata_o holds its value when there is no read.
REQ-024 SHALL run per-channel FSM states IDLE and RUN.
REQ-025 IDLE: a write with ctrl word 0 bit0=1 and be_i[0]=1 SHALL pulse start_o the next cycle and enter RUN; the other written bits are stored.
REQ-026 Ctrl word 0 bit0 (start) and bit1 (abort) SHALL be self-clearing and SHALL read as 0.
REQ-027 RUN: done_i SHALL set IRQ_PEND[c] and return the channel to IDLE.
REQ-028 RUN: a write with ctrl word 0 bit1=1 SHALL pulse abort_o the next cycle and return to IDLE without setting pending.
REQ-029 RUN: writes to any ctrl word of channel c SHALL be dropped and SHALL set sticky WR_ERR[c]; start requests SHALL be ignored.
REQ-030 done_i in IDLE SHALL be ignored.
REQ-031 Status word 0 SHALL be {zeros, WR_ERR, PEND, BUSY} at bits [2:0]; BUSY=1 in RUN.
REQ-032 A write to status word 0 with bit2=1 SHALL clear WR_ERR (W1C, only exception to REQ-021).
REQ-033 IRQ_PEND SHALL be W1C; when set and clear coincide in the same cycle, set wins.
REQ-034 When done_i and an abort write coincide in RUN, done wins: pending is set and no abort_o pulse occurs.
REQ-035 irq_o SHALL be registered |(IRQ_PEND & IRQ_EN[N_CH-1:0]), one cycle after the causing event.

Reset
REQ-036 rst SHALL force all channels to IDLE and clear all ctrl words, IRQ_EN, IRQ_PEND, WR_ERR, rdata_o, start_o, abort_o and irq_o to 0, including during RUN; no abort_o pulse SHALL be issued on reset.

Structure
REQ-037 The ch_state_t enum (IDLE, RUN) and the global-offset constants SHALL live in cfg_types_pkg.
REQ-038 The per-channel FSM, ctrl words and WR_ERR SHALL be one sub-module accel_ch_ctrl, instantiated N_CH times via generate.

Verification
REQ-039 Defaults, write ch0 word0=0x0000_0501 -> start_o[0] pulses 1 cycle; ch0 word0 reads 0x0000_0500; ch0 status0 reads 0x1.
REQ-040 RUN ch0, done_i[0] with IRQ_EN=0x1 -> status0=0x2, IRQ_PEND=0x1, irq_o=1 next cycle; write IRQ_PEND=0x1 -> irq_o=0.
REQ-041 RUN ch1, write ch1 word1=0xDEAD_BEEF -> word1 unchanged, status0=0x5; write status0=0x4 -> status0=0x1.
REQ-042 RUN ch0, abort write and done_i[0] in the same cycle -> no abort_o, PEND=1; separate abort -> abort_o pulse, status0=0x0.
REQ-043 Assert rst in RUN -> all reads return 0, no start_o/abort_o pulse, irq_o=0.
REQ-044 Read unmapped address (N_CH*W+2) -> 0; write with be_i=0x2 to ch0 word1 -> only bits [15:8] change.
